// File: rtl/dump_pkg.sv
// Shared types and constants for the capture RAM dump controller.
package dump_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LATCH = 3'd2,
        S_SEND  = 3'd3,
        S_WAIT  = 3'd4,
        S_DONE  = 3'd5
    } dump_state_t;

    // Upper six bits form the header marker; the low two carry the channel.
    localparam logic [7:0] HDR_MARK = 8'hA0;

    localparam logic [1:0] CH1        = 2'd0;
    localparam logic [1:0] CH2        = 2'd1;
    localparam logic [1:0] CH3        = 2'd2;
    localparam logic [1:0] CH_INVALID = 2'd3;

endpackage

// File: rtl/circ_addr_ctr.sv
// Circular counter over 0..DEPTH-1: load, increment with explicit wrap,
// terminal-count flag. Out-of-range load values are folded to 0.
module circ_addr_ctr #(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [AW-1:0] load_val,
    input  logic          inc,
    output logic [AW-1:0] value,
    output logic          tc
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [AW-1:0] val_d, val_q;

    // Next value: load takes priority over increment; wrap at DEPTH-1.
    always_comb begin
        val_d = val_q;
        if (load) begin
            val_d = (load_val > LAST) ? '0 : load_val;
        end else if (inc) begin
            val_d = (val_q == LAST) ? '0 : val_q + AW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) val_q <= '0;
        else     val_q <= val_d;
    end

    assign value = val_q;
    assign tc    = (val_q == LAST);

endmodule

// File: rtl/ram_dump_ctrl.sv
// Dumps one channel's circular capture buffer, oldest sample first, to the
// UART transmitter using a trmt/tx_done handshake.
// Optional macro DUMP_HEADER_EN: prepend a header byte {HDR_MARK[7:2], ch_sel}.
//
// state   | meaning
// S_IDLE  | waiting for start_dump
// S_READ  | RAM read enable asserted at addr
// S_LATCH | RAM data of the selected channel captured into tx_data
// S_SEND  | trmt strobe to the UART
// S_WAIT  | waiting for tx_done, then advance or finish
// S_DONE  | finish pulses, then back to idle
module ram_dump_ctrl
    import dump_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int AW    = 9,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_dump,
    input  logic [1:0]    ch_sel,
    input  logic [AW-1:0] end_addr,
    input  logic [DW-1:0] rdata_ch1,
    input  logic [DW-1:0] rdata_ch2,
    input  logic [DW-1:0] rdata_ch3,
    output logic          en,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] tx_data,
    output logic          trmt,
    input  logic          tx_done,
    output logic          busy,
    output logic          dump_finished,
    output logic          clr_capture_done
);

    dump_state_t   state_d, state_q;
    logic          en_d, en_q;
    logic [DW-1:0] tx_data_d, tx_data_q;
    logic          trmt_d, trmt_q;
    logic          busy_d, busy_q;
    logic          fin_d, fin_q;
    logic          clr_d, clr_q;
    logic [1:0]    ch_d, ch_q;
    logic          hdr_d, hdr_q;

    logic          ctr_load, ctr_inc;
    logic          cnt_tc;
    logic          unused_addr_tc;
    logic [AW-1:0] unused_cnt_val;

    // Read address walks the circular buffer from end_addr.
    circ_addr_ctr #(.DEPTH(DEPTH), .AW(AW)) u_addr_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (ctr_load),
        .load_val (end_addr),
        .inc      (ctr_inc),
        .value    (addr),
        .tc       (unused_addr_tc)
    );

    // Sample counter: its terminal count marks the last byte of the dump.
    circ_addr_ctr #(.DEPTH(DEPTH), .AW(AW)) u_cnt_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (ctr_load),
        .load_val ('0),
        .inc      (ctr_inc),
        .value    (unused_cnt_val),
        .tc       (cnt_tc)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_d   = state_q;
        en_d      = 1'b0;
        trmt_d    = 1'b0;
        fin_d     = 1'b0;
        clr_d     = 1'b0;
        tx_data_d = tx_data_q;
        busy_d    = busy_q;
        ch_d      = ch_q;
        hdr_d     = hdr_q;
        ctr_load  = 1'b0;
        ctr_inc   = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start_dump && !busy_q) begin
                    busy_d = 1'b1;
                    ch_d   = ch_sel;
                    if (ch_sel == CH_INVALID) begin
                        state_d = S_DONE;
                    end else begin
                        ctr_load = 1'b1;
`ifdef DUMP_HEADER_EN
                        hdr_d     = 1'b1;
                        tx_data_d = DW'({HDR_MARK[7:2], ch_sel});
                        trmt_d    = 1'b1;
                        state_d   = S_SEND;
`else
                        en_d    = 1'b1;
                        state_d = S_READ;
`endif
                    end
                end
            end
            S_READ: state_d = S_LATCH;
            S_LATCH: begin
                case (ch_q)
                    CH1:     tx_data_d = rdata_ch1;
                    CH2:     tx_data_d = rdata_ch2;
                    default: tx_data_d = rdata_ch3;
                endcase
                trmt_d  = 1'b1;
                state_d = S_SEND;
            end
            S_SEND: state_d = S_WAIT;
            S_WAIT: begin
                if (tx_done) begin
                    if (hdr_q) begin
                        // Header sent: first RAM read at the loaded address.
                        hdr_d   = 1'b0;
                        en_d    = 1'b1;
                        state_d = S_READ;
                    end else if (cnt_tc) begin
                        state_d = S_DONE;
                    end else begin
                        ctr_inc = 1'b1;
                        en_d    = 1'b1;
                        state_d = S_READ;
                    end
                end
            end
            S_DONE: begin
                fin_d   = 1'b1;
                clr_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            en_q      <= 1'b0;
            tx_data_q <= '0;
            trmt_q    <= 1'b0;
            busy_q    <= 1'b0;
            fin_q     <= 1'b0;
            clr_q     <= 1'b0;
            ch_q      <= CH1;
            hdr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            tx_data_q <= tx_data_d;
            trmt_q    <= trmt_d;
            busy_q    <= busy_d;
            fin_q     <= fin_d;
            clr_q     <= clr_d;
            ch_q      <= ch_d;
            hdr_q     <= hdr_d;
        end
    end

    assign en               = en_q;
    assign tx_data          = tx_data_q;
    assign trmt             = trmt_q;
    assign busy             = busy_q;
    assign dump_finished    = fin_q;
    assign clr_capture_done = clr_q;

endmodule

// File: tb/tb_ram_dump_ctrl.sv
// Testbench for ram_dump_ctrl: RAM and UART models, a queue-based model of
// the expected read addresses and byte stream, and directed scenarios.
module tb_ram_dump_ctrl;

    localparam int DEPTH = 512;
    localparam int AW    = 9;
    localparam int DW    = 8;
`ifdef DUMP_HEADER_EN
    localparam int HOFF = 1;
`else
    localparam int HOFF = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_dump = 1'b0;
    logic [1:0]    ch_sel = 2'd0;
    logic [AW-1:0] end_addr = '0;
    logic [DW-1:0] rdata_ch1 = '0;
    logic [DW-1:0] rdata_ch2 = '0;
    logic [DW-1:0] rdata_ch3 = '0;
    logic          tx_done = 1'b0;
    logic          en, trmt, busy, dump_finished, clr_capture_done;
    logic [AW-1:0] addr;
    logic [DW-1:0] tx_data;

    ram_dump_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk              (clk),
        .rst              (rst),
        .start_dump       (start_dump),
        .ch_sel           (ch_sel),
        .end_addr         (end_addr),
        .rdata_ch1        (rdata_ch1),
        .rdata_ch2        (rdata_ch2),
        .rdata_ch3        (rdata_ch3),
        .en               (en),
        .addr             (addr),
        .tx_data          (tx_data),
        .trmt             (trmt),
        .tx_done          (tx_done),
        .busy             (busy),
        .dump_finished    (dump_finished),
        .clr_capture_done (clr_capture_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int fin_count = 0;
    bit glitch = 1'b0;

    logic [DW-1:0] ram [3][DEPTH];
    logic [DW-1:0] exp_bytes [$];
    logic [AW-1:0] exp_addr [$];
    logic [DW-1:0] rx_log [$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // RAM contents: ram[c][i] = (7*i + 31*c + 5) mod 256.
    initial begin
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < DEPTH; i++)
                ram[c][i] = 8'((i * 7 + c * 31 + 5) % 256);
    end

    // RAM read ports: data appears one cycle after en.
    initial begin
        logic          ren;
        logic [AW-1:0] ra;
        forever begin
            @(negedge clk);
            ren = en;
            ra  = addr;
            @(posedge clk);
            #1;
            if (ren) begin
                rdata_ch1 = ram[0][ra];
                rdata_ch2 = ram[1][ra];
                rdata_ch3 = ram[2][ra];
            end
        end
    end

    // UART: tx_done 10 cycles after each trmt; optional spurious tx_done
    // pulses while the controller is in READ or SEND.
    initial begin
        int uart_cnt  = 0;
        bit uart_busy = 1'b0;
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (uart_cnt > 0) begin
                uart_cnt--;
                if (uart_cnt == 0) begin
                    tx_done   = 1'b1;
                    uart_busy = 1'b0;
                end
            end
            if (trmt) begin
                check("uart_overlap", int'(uart_busy), 0);
                uart_busy = 1'b1;
                uart_cnt  = 10;
                if (glitch) tx_done = 1'b1;
            end
            if (glitch && en) tx_done = 1'b1;
        end
    end

    // Compare process: DUT outputs against the model queues every cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (en) begin
                check("en_expected", int'(exp_addr.size() > 0), 1);
                if (exp_addr.size() > 0) check("rd_addr", int'(addr), int'(exp_addr.pop_front()));
            end
            if (trmt) begin
                rx_log.push_back(tx_data);
                check("trmt_expected", int'(exp_bytes.size() > 0), 1);
                if (exp_bytes.size() > 0) check("tx_byte", int'(tx_data), int'(exp_bytes.pop_front()));
            end
            if (dump_finished || clr_capture_done)
                check("clr_with_fin", int'(clr_capture_done), int'(dump_finished));
            if (dump_finished) begin
                fin_count++;
                check("fin_bytes_left", exp_bytes.size(), 0);
            end
        end
    end

    task automatic model_start(input int ch, input int ea);
        int a;
`ifdef DUMP_HEADER_EN
        exp_bytes.push_back(8'(8'hA0 + ch));
`endif
        for (int i = 0; i < DEPTH; i++) begin
            a = (ea + i) % DEPTH;
            exp_addr.push_back(AW'(a));
            exp_bytes.push_back(ram[ch][a]);
        end
    endtask

    task automatic pulse_start(input int ch, input int ea);
        @(negedge clk);
        ch_sel     = 2'(ch);
        end_addr   = AW'(ea);
        start_dump = 1'b1;
        @(negedge clk);
        start_dump = 1'b0;
    endtask

    task automatic wait_fin(input int prev, input int budget);
        int n = 0;
        while (fin_count == prev && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("fin_in_time", fin_count, prev + 1);
    endtask

    task automatic wait_rx(input int cnt, input int budget);
        int n = 0;
        while (rx_log.size() < cnt && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("rx_in_time", int'(rx_log.size() >= cnt), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_en"},   int'(en), 0);
        check({tag, "_addr"}, int'(addr), 0);
        check({tag, "_txd"},  int'(tx_data), 0);
        check({tag, "_trmt"}, int'(trmt), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_fin"},  int'(dump_finished), 0);
        check({tag, "_clr"},  int'(clr_capture_done), 0);
    endtask

    initial begin
        int f0;

        // Reset state.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // CH1 from address 0, with spurious tx_done in READ and SEND.
        glitch = 1'b1;
        rx_log.delete();
        f0 = fin_count;
        model_start(0, 0);
        pulse_start(0, 0);
        wait_fin(f0, 12000);
        repeat (3) @(negedge clk);
        glitch = 1'b0;
        check("t1_busy_after", int'(busy), 0);
        check("t1_fin_count", fin_count, f0 + 1);
        check("t1_bytes", rx_log.size(), DEPTH + HOFF);
        check("t1_first", int'(rx_log[HOFF]), 8'h05);
`ifdef DUMP_HEADER_EN
        check("t1_header", int'(rx_log[0]), 8'hA0);
`endif

        // CH3 from address 500: wraps 511 -> 0.
        rx_log.delete();
        f0 = fin_count;
        model_start(2, 500);
        pulse_start(2, 500);
        wait_fin(f0, 12000);
        repeat (3) @(negedge clk);
        check("t2_bytes", rx_log.size(), DEPTH + HOFF);
        check("t2_first", int'(rx_log[HOFF]), 8'hEF);
        check("t2_at511", int'(rx_log[HOFF + 11]), 8'h3C);
        check("t2_at0", int'(rx_log[HOFF + 12]), 8'h43);

        // Invalid channel: no reads, finish pulse in the second busy cycle.
        f0 = fin_count;
        @(negedge clk);
        ch_sel     = 2'd3;
        start_dump = 1'b1;
        @(negedge clk);
        start_dump = 1'b0;
        check("inv_busy1", int'(busy), 1);
        check("inv_fin1", int'(dump_finished), 0);
        @(negedge clk);
        check("inv_busy2", int'(busy), 1);
        check("inv_fin2", int'(dump_finished), 1);
        check("inv_clr2", int'(clr_capture_done), 1);
        @(negedge clk);
        check("inv_busy3", int'(busy), 0);
        check("inv_fin3", int'(dump_finished), 0);
        repeat (3) @(negedge clk);
        check("inv_fin_count", fin_count, f0 + 1);

        // Second start_dump mid-dump is ignored; ch_sel/end_addr changes too.
        rx_log.delete();
        f0 = fin_count;
        model_start(1, 300);
        pulse_start(1, 300);
        wait_rx(100 + HOFF, 3000);
        pulse_start(0, 7);
        wait_fin(f0, 12000);
        repeat (20) @(negedge clk);
        check("t4_bytes", rx_log.size(), DEPTH + HOFF);
        check("t4_fin_count", fin_count, f0 + 1);
        check("t4_first", int'(rx_log[HOFF]), 8'h58);
        check("t4_busy_after", int'(busy), 0);

        // Reset while waiting on byte 37, then a clean restart.
        rx_log.delete();
        model_start(2, 10);
        pulse_start(2, 10);
        wait_rx(37 + HOFF, 2000);
        repeat (3) @(negedge clk);
        f0 = fin_count;
        rst = 1'b1;
        exp_bytes.delete();
        exp_addr.delete();
        @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("midrst_no_fin", fin_count, f0);
        rx_log.delete();
        model_start(2, 10);
        pulse_start(2, 10);
        wait_fin(f0, 12000);
        repeat (3) @(negedge clk);
        check("t5_bytes", rx_log.size(), DEPTH + HOFF);
        check("t5_first", int'(rx_log[HOFF]), 8'h89);
        check("t5_fin_count", fin_count, f0 + 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard stop if the sequence above ever stalls.
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ram_dump_ctrl.md
Name: ram_dump_ctrl

Overview:
Sequences readout of the three per-channel capture RAMs to the UART transmitter after a capture completes. On start_dump it reads one channel's circular buffer oldest-first, starting at the capture end address and wrapping at DEPTH. Each byte goes to the UART with a trmt/tx_done handshake. It sits between the command decoder, the capture RAM read ports and the UART TX, and clears capture_done when the dump ends so capture can re-arm.

Parameters:
DEPTH, 512, samples per channel RAM; any value 2..2^AW
AW, 9, RAM address width
DW, 8, sample/byte width

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
start_dump  input  1  one-cycle request from command decoder
ch_sel  input  2  channel to dump: 0=CH1, 1=CH2, 2=CH3, 3=invalid
end_addr  input  AW  oldest-sample address (next write address of capture)
rdata_ch1  input  DW  CH1 RAM read data, valid 1 cycle after en
rdata_ch2  input  DW  CH2 RAM read data
rdata_ch3  input  DW  CH3 RAM read data
en  output  1  RAM read enable (all channel RAMs)
addr  output  AW  RAM read address
tx_data  output  DW  byte to UART
trmt  output  1  one-cycle transmit strobe
tx_done  input  1  UART byte-complete pulse
busy  output  1  high from acceptance of start_dump until DONE exits
dump_finished  output  1  one-cycle pulse at end of dump
clr_capture_done  output  1  one-cycle pulse, same cycle as dump_finished

Behaviour:
- Reset (synchronous, rst=1 at clk edge): state IDLE; en=0, addr=0, tx_data=0, trmt=0, busy=0, dump_finished=0, clr_capture_done=0; sample counter=0. Reset mid-dump abandons the dump immediately. No pulse is issued. Any UART byte already in flight completes externally and is ignored.
- States: IDLE, READ, LATCH, SEND, WAIT, DONE.
- IDLE: when start_dump=1, latch ch_sel and end_addr. Then go READ with addr=end_addr and count=0. Exception: when ch_sel=3, go DONE directly, so zero bytes are sent and dump_finished fires 1 cycle later.
- READ: en=1 for exactly this cycle, then go LATCH.
- LATCH: register the selected rdata into tx_data, then go SEND.
- SEND: trmt=1 for one cycle, then go WAIT.
- WAIT: hold until tx_done=1.
  - If count==DEPTH-1, go DONE.
  - Otherwise count+=1, addr=(addr==DEPTH-1)?0:addr+1, then go READ.
- DONE: dump_finished=1 and clr_capture_done=1 for one cycle, then go IDLE. busy drops in the IDLE cycle.
- Latency: start_dump at edge k gives en at cycle k+1, tx_data valid at k+3, and first trmt at k+3. Per byte: 3 cycles plus UART time.
- start_dump while busy is ignored; it is neither queued nor a restart. ch_sel and end_addr changes during a dump have no effect.
- tx_done outside WAIT is ignored. A tx_done in the same cycle as trmt (SEND) is also ignored.
- Wrap: addr wraps DEPTH-1 to 0 explicitly, so non-power-of-2 DEPTH is legal. end_addr>=DEPTH is treated as 0.
- Exactly DEPTH bytes are sent per valid dump, in order end_addr, end_addr+1, … (mod DEPTH).
- addr holds its last value outside READ. en=0 in all states except READ.

Optional Feature:
DUMP_HEADER_EN
- Defined: after start_dump, a header byte {HDR_MARK[7:2], ch_sel} (HDR_MARK=8'hA0) is sent through SEND/WAIT before the first RAM read. Valid dumps are DEPTH+1 bytes, and first trmt is at k+1. An invalid ch_sel sends no header.
- Undefined: no header; behaviour is as described above.

Decomposition:
- dump_pkg holds:
  - state enum dump_state_t
  - HDR_MARK constant
  - channel encodings CH1/CH2/CH3/CH_INVALID
- One sub-module, circ_addr_ctr (parameters DEPTH, AW): load, increment-with-wrap and terminal-count flag. It is used for both addr and count.

Test Plan:
- Reset then start_dump, ch_sel=0, end_addr=0, DEPTH=512, UART model tx_done 10 cycles after trmt -> 512 bytes equal to CH1 RAM[0..511]; one dump_finished and one clr_capture_done pulse; busy low afterwards.
- end_addr=500, ch_sel=2 -> byte order RAM3[500..511] then RAM3[0..499]; addr goes 511 then 0 with no gap.
- start_dump with ch_sel=3 -> no en, no trmt; dump_finished 2 cycles after start_dump; busy high for 2 cycles.
- Second start_dump pulsed at byte 100 of a running dump -> ignored; total still 512 bytes; exactly one dump_finished.
- rst asserted at byte 37 (in WAIT) -> next cycle all outputs 0 with no dump_finished pulse; a subsequent start_dump restarts from end_addr.
- DUMP_HEADER_EN defined, ch_sel=1 -> first byte 8'hA1, then 512 samples; tx_done pulsed during SEND is ignored and does not advance.
